adv_vid_fmt: RTL and testbench



---
 rtl/adv_vid_pkg.sv | 28 ++
 rtl/adv_timing_ctr.sv | 59 +++++
 rtl/adv_vid_fmt.sv | 104 ++++++++++
 tb/tb_adv_vid_fmt.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adv_vid_pkg.sv
// rtl/adv_vid_pkg.sv - timing presets and width helpers for the ADV75xx pixel formatter
package adv_vid_pkg;

  // 1280x720 at 60 Hz as wired on the reference carrier
  localparam int T720_H_TO_DE  = 25;
  localparam int T720_H_ACT    = 1280;
  localparam int T720_H_TOTAL  = 1360;
  localparam int T720_V_TO_DE  = 9;
  localparam int T720_V_ACT    = 720;
  localparam int T720_V_TOTAL  = 806;

  // 1920x1080 at 30 Hz
  localparam int T1080_H_TO_DE = 192;
  localparam int T1080_H_ACT   = 1920;
  localparam int T1080_H_TOTAL = 2200;
  localparam int T1080_V_TO_DE = 41;
  localparam int T1080_V_ACT   = 1080;
  localparam int T1080_V_TOTAL = 1125;

  function automatic int ph_of(input int data_w, input int bus_w);
    return data_w / bus_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adv_timing_ctr.sv
// rtl/adv_timing_ctr.sv - per-pixel H/V counters, sync edge detect and DE window
module adv_timing_ctr
  import adv_vid_pkg::*;
#(
  parameter int H_TO_DE = T720_H_TO_DE,
  parameter int H_ACT   = T720_H_ACT,
  parameter int H_TOTAL = T720_H_TOTAL,
  parameter int V_TO_DE = T720_V_TO_DE,
  parameter int V_ACT   = T720_V_ACT,
  parameter int V_TOTAL = T720_V_TOTAL
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        hs_act,
  input  logic                        vs_act,
  output logic                        de_win,
  output logic                        fs_edge,
  output logic [cnt_w(V_TOTAL)-1:0]   v_count
);

  localparam int HW = cnt_w(H_TOTAL);
  localparam int VW = cnt_w(V_TOTAL);

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v_nxt;
  logic          hs_prev, vs_prev, hs_edge;

  // DE window is judged on the post-update counters of the pixel being captured
  always_comb begin
    hs_edge = hs_act && !hs_prev;
    fs_edge = vs_act && !vs_prev;
    h_nxt   = h + 1'b1;
    if (hs_edge || h == HW'(H_TOTAL - 1))
      h_nxt = '0;
    v_nxt = v_count;
    if (vs_act)
      v_nxt = '0;
    else if (hs_edge && v_count != VW'(V_TOTAL - 1))
      v_nxt = v_count + 1'b1;
    de_win = (int'(h_nxt) >= H_TO_DE) && (int'(h_nxt) < H_TO_DE + H_ACT) &&
             (int'(v_nxt) > V_TO_DE) && (int'(v_nxt) <= V_TO_DE + V_ACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h       <= '0;
      v_count <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else if (ce) begin
      h       <= h_nxt;
      v_count <= v_nxt;
      hs_prev <= hs_act;
      vs_prev <= vs_act;
    end
  end

endmodule

// File: rtl/adv_vid_fmt.sv
// rtl/adv_vid_fmt.sv - pixel capture, bus slicing and phase checking for ADV75xx transmitters
module adv_vid_fmt
  import adv_vid_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int BUS_W   = 12,
  parameter int H_TO_DE = T720_H_TO_DE,
  parameter int H_ACT   = T720_H_ACT,
  parameter int H_TOTAL = T720_H_TOTAL,
  parameter int V_TO_DE = T720_V_TO_DE,
  parameter int V_ACT   = T720_V_ACT,
  parameter int V_TOTAL = T720_V_TOTAL,
  parameter bit DE_GEN  = 1'b1,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_ce,
  input  logic [DATA_W-1:0]         data,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      de_in,
  output logic [BUS_W-1:0]          data_out,
  output logic                      de_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      clk_pixel_out,
  output logic                      frame_start,
  output logic                      phase_err,
  output logic [cnt_w(V_TOTAL)-1:0] v_count
);

  localparam int PH   = ph_of(DATA_W, BUS_W);
  localparam int PH_W = cnt_w(PH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH - 1);
  localparam logic [PH_W-1:0] CLK_HI  = PH_W'((PH + 1) / 2);

  logic [PH_W-1:0]   ph, ph_nxt;
  logic              idle;
  logic [DATA_W-1:0] shreg;
  logic              de_win, fs_edge;

  adv_timing_ctr #(
    .H_TO_DE(H_TO_DE), .H_ACT(H_ACT), .H_TOTAL(H_TOTAL),
    .V_TO_DE(V_TO_DE), .V_ACT(V_ACT), .V_TOTAL(V_TOTAL)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .ce      (pix_ce),
    .hs_act  (hsync == HS_POL),
    .vs_act  (vsync == VS_POL),
    .de_win  (de_win),
    .fs_edge (fs_edge),
    .v_count (v_count)
  );

  always_comb begin
    ph_nxt = ph;
    if (pix_ce)
      ph_nxt = '0;
    else if (ph != PH_LAST)
      ph_nxt = ph + 1'b1;
  end

  // Slices are shifted out LSB first; ph parks at PH_LAST when a pixel is late
  always_ff @(posedge clk) begin
    if (reset) begin
      ph            <= PH_LAST;
      idle          <= 1'b1;
      shreg         <= '0;
      data_out      <= '0;
      de_out        <= 1'b0;
      hsync_out     <= 1'b0;
      vsync_out     <= 1'b0;
      clk_pixel_out <= 1'b0;
      frame_start   <= 1'b0;
      phase_err     <= 1'b0;
    end else begin
      frame_start   <= 1'b0;
      phase_err     <= 1'b0;
      clk_pixel_out <= (PH > 1) && (ph_nxt < CLK_HI);
      ph            <= ph_nxt;
      if (pix_ce) begin
        idle        <= 1'b0;
        data_out    <= data[BUS_W-1:0];
        shreg       <= data >> BUS_W;
        de_out      <= DE_GEN ? de_win : de_in;
        hsync_out   <= hsync;
        vsync_out   <= vsync;
        frame_start <= fs_edge;
        phase_err   <= !idle && (ph != PH_LAST);
      end else if (ph != PH_LAST) begin
        data_out <= shreg[BUS_W-1:0];
        shreg    <= shreg >> BUS_W;
      end else if (!idle) begin
        idle      <= 1'b1;
        phase_err <= 1'b1;
        de_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adv_vid_fmt.sv
// tb/tb_adv_vid_fmt.sv - table and scoreboard bench for adv_vid_fmt
`timescale 1ns/1ps
module tb_adv_vid_fmt;

  logic        clk = 1'b0, reset = 1'b1;
  logic        pix_ce = 1'b0, hsync = 1'b0, vsync = 1'b0, de_in = 1'b0;
  logic [23:0] data = '0;
  logic        pix_ce3 = 1'b0, hsync3 = 1'b0, vsync3 = 1'b0, de_in3 = 1'b0;
  logic [23:0] data3 = '0;

  always #5 clk = ~clk;

  logic [11:0] d2, d0;
  logic [7:0]  d3;
  logic        de2, hs2, vs2, ck2, fs2, pe2;
  logic        de0, hs0, vs0, ck0, fs0, pe0;
  logic        de3, hs3, vs3, ck3, fs3, pe3;
  logic [2:0]  vc2, vc0, vc3;

  adv_vid_fmt #(.DATA_W(24), .BUS_W(12), .H_TO_DE(2), .H_ACT(4), .H_TOTAL(8),
                .V_TO_DE(1), .V_ACT(2), .V_TOTAL(5), .DE_GEN(1'b1)) u2 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .data(data), .hsync(hsync), .vsync(vsync),
    .de_in(de_in), .data_out(d2), .de_out(de2), .hsync_out(hs2), .vsync_out(vs2),
    .clk_pixel_out(ck2), .frame_start(fs2), .phase_err(pe2), .v_count(vc2));

  adv_vid_fmt #(.DATA_W(24), .BUS_W(12), .H_TO_DE(2), .H_ACT(4), .H_TOTAL(8),
                .V_TO_DE(1), .V_ACT(2), .V_TOTAL(5), .DE_GEN(1'b0)) u0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .data(data), .hsync(hsync), .vsync(vsync),
    .de_in(de_in), .data_out(d0), .de_out(de0), .hsync_out(hs0), .vsync_out(vs0),
    .clk_pixel_out(ck0), .frame_start(fs0), .phase_err(pe0), .v_count(vc0));

  adv_vid_fmt #(.DATA_W(24), .BUS_W(8), .H_TO_DE(2), .H_ACT(4), .H_TOTAL(8),
                .V_TO_DE(1), .V_ACT(2), .V_TOTAL(5), .DE_GEN(1'b1)) u3 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce3), .data(data3), .hsync(hsync3), .vsync(vsync3),
    .de_in(de_in3), .data_out(d3), .de_out(de3), .hsync_out(hs3), .vsync_out(vs3),
    .clk_pixel_out(ck3), .frame_start(fs3), .phase_err(pe3), .v_count(vc3));

  typedef struct {
    logic [23:0] data;
    logic        hs, vs, dein;
    logic [11:0] s0, s1;
    logic        de_g, fs, perr;
    logic [2:0]  vc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source timing: hsync on pixel 0 of each line, vsync through line 0
  function automatic vec_t mk_row(input int ln, input int p, input int v, input int h);
    vec_t r;
    r.data = (ln == 0 && p == 0) ? 24'hABC123 : 24'($urandom);
    r.s0   = r.data[11:0];
    r.s1   = r.data[23:12];
    if (ln == 0 && p == 0) begin
      r.s0 = 12'h123;
      r.s1 = 12'hABC;
    end
    r.hs   = (p == 0);
    r.vs   = (ln == 0);
    r.dein = (p % 3 != 1);
    r.de_g = (v >= 2 && v <= 3 && h >= 2 && h <= 5);
    r.fs   = (ln == 0 && p == 0);
    r.perr = 1'b0;
    r.vc   = 3'(v);
    return r;
  endfunction

  function automatic vec_t mk_plain(input logic [23:0] d, input logic dein, input logic perr);
    vec_t r;
    r.data = d;  r.s0 = d[11:0];  r.s1 = d[23:12];
    r.hs = 1'b0; r.vs = 1'b0; r.dein = dein; r.de_g = 1'b0;
    r.fs = 1'b0; r.perr = perr; r.vc = 3'd0;
    return r;
  endfunction

  task automatic start_px(input vec_t r);
    sb.push_back(r);
    pix_ce = 1'b1; data = r.data; hsync = r.hs; vsync = r.vs; de_in = r.dein;
  endtask

  task automatic px(input vec_t r, input int gap);
    start_px(r);
    @(posedge clk); #1;
    pix_ce = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_u2"}, {d2, de2, hs2, vs2, ck2, fs2, pe2, vc2}, 0);
    chk({nm, "_u0"}, {d0, de0, hs0, vs0, ck0, fs0, pe0, vc0}, 0);
    chk({nm, "_u3"}, {d3, de3, hs3, vs3, ck3, fs3, pe3, vc3}, 0);
  endtask

  // Scoreboard monitor for the two PH=2 instances sharing one stimulus stream
  vec_t cur;
  int   slot = 99;
  bit   cap_pending = 1'b0;

  always @(negedge clk) begin
    if (cap_pending) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow actual=empty expected=entry at %0t", $time);
      end else begin
        cur  = sb.pop_front();
        slot = 0;
        chk("slice0_u2", d2, cur.s0);
        chk("slice0_u0", d0, cur.s0);
        chk("de_gen", de2, cur.de_g);
        chk("de_pass", de0, cur.dein);
        chk("hsync_out", hs2, cur.hs);
        chk("vsync_out", vs2, cur.vs);
        chk("frame_start", fs2, cur.fs);
        chk("clk_pix_s0", ck2, 1);
        chk("phase_err_s0", pe2, cur.perr);
        chk("v_count", vc2, cur.vc);
      end
    end else if (slot < 1) begin
      slot++;
      chk("slice1_u2", d2, cur.s1);
      chk("de_gen_hold", de2, cur.de_g);
      chk("de_pass_hold", de0, cur.dein);
      chk("clk_pix_s1", ck2, 0);
      chk("frame_start_s1", fs2, 0);
      chk("phase_err_s1", pe2, 0);
    end
    if (reset) slot = 99;
    cap_pending = pix_ce && !reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  logic [23:0] v3 [3];
  logic [7:0]  e3 [3][3];

  initial begin
    // Table: one normal frame, then a frame with a 12-pixel line 3 and an extra sixth line
    for (int ln = 0; ln < 5; ln++)
      for (int p = 0; p < 8; p++)
        tbl.push_back(mk_row(ln, p, ln, p));
    for (int ln = 0; ln < 6; ln++)
      for (int p = 0; p < ((ln == 3) ? 12 : 8); p++)
        tbl.push_back(mk_row(ln, p, (ln > 4) ? 4 : ln, p % 8));

    v3[0] = 24'h112233; e3[0][0] = 8'h33; e3[0][1] = 8'h22; e3[0][2] = 8'h11;
    v3[1] = 24'h445566; e3[1][0] = 8'h66; e3[1][1] = 8'h55; e3[1][2] = 8'h44;
    v3[2] = 24'hA5C30F; e3[2][0] = 8'h0F; e3[2][1] = 8'hC3; e3[2][2] = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Spacing 1 then 3: early pixel B, then late gap before C
    px(mk_plain(24'h13579B, 1'b1, 1'b0), 1);
    px(mk_plain(24'h2468AC, 1'b1, 1'b1), 2);
    @(posedge clk); #1;
    start_px(mk_plain(24'hFEDCBA, 1'b0, 1'b0));
    @(negedge clk);
    chk("late_phase_err", pe2, 1);
    chk("late_phase_err_u0", pe0, 1);
    chk("late_de_forced", de0, 0);
    chk("late_data_hold", d2, 12'h246);
    chk("late_clk_pix", ck2, 0);
    @(posedge clk); #1;
    pix_ce = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      px(tbl[i], 2);

    // Reset at v=2, h=3 while DE is high
    for (int i = 0; i < 19; i++)
      px(mk_row(i / 8, i % 8, i / 8, i % 8), 2);
    px(mk_row(2, 3, 2, 3), 1);
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    for (int p = 4; p < 8; p++) px(mk_row(2, p, 0, p), 2);
    for (int p = 0; p < 8; p++) px(mk_row(3, p, 1, p), 2);
    for (int ln = 0; ln < 5; ln++)
      for (int p = 0; p < 8; p++)
        px(mk_row(ln, p, ln, p), 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    // PH=3 instance: three back-to-back pixels
    pix_ce3 = 1'b1; data3 = v3[0];
    @(posedge clk); #1;
    pix_ce3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        chk($sformatf("ph3_slice%0d_%0d", k, s), d3, e3[k][s]);
        chk($sformatf("ph3_clk%0d_%0d", k, s), ck3, (s < 2) ? 1 : 0);
        chk($sformatf("ph3_perr%0d_%0d", k, s), pe3, 0);
        @(posedge clk); #1;
        if (s == 1 && k < 2) begin
          pix_ce3 = 1'b1; data3 = v3[k + 1];
        end else begin
          pix_ce3 = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
